// File: rtl/lc256_mmu_gen.sv
// LC256 glue/MMU decoder: address decode, RAM banking, ROM enables, I/O slot strobes,
// slow-slot wait-state insertion and DMA bus handoff, all clocked on PHI2.
module lc256_mmu_gen #(
    parameter int               BANK_BITS = 2,
    parameter int               NSLOTS    = 4,
    parameter int               WAIT_CYC  = 2,
    parameter logic [NSLOTS-1:0] SLOW_MASK = 4'b0100,
    parameter logic [5:0]       IO_BASE   = 6'b110111
) (
    input  logic                 PHI2,
    input  logic                 RESET,
    input  logic [15:0]          A,
    input  logic                 R_W,
    input  logic                 SYNC,
    input  logic                 _DMA,
    input  logic [7:0]           D,
    output logic [7:0]           DOUT,
    output logic                 DOE,
    output logic                 RDY,
    output logic                 BA,
    output logic [BANK_BITS-1:0] BANK,
    output logic                 _RAM0,
    output logic                 _RAM1,
    output logic                 _ROM,
    output logic                 _IO,
    output logic [NSLOTS-1:0]    _CS_RD,
    output logic [NSLOTS-1:0]    _CS_WR
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DONE  = 2'd2,
        ST_DMA   = 2'd3
    } st_t;

    localparam logic [3:0] NSLOTS4  = 4'(NSLOTS);
    localparam logic [7:0] SLOW8    = 8'(SLOW_MASK);
    localparam logic       HAS_WAIT = (WAIT_CYC != 0) ? 1'b1 : 1'b0;
    localparam logic       ONE_WAIT = (WAIT_CYC == 1) ? 1'b1 : 1'b0;
    // STALL counts down to zero, so it holds WAIT_CYC-2 on entry (RUN and STALL-at-0 make up the rest)
    localparam logic [3:0] CNT_INIT = (WAIT_CYC >= 2) ? 4'(WAIT_CYC - 2) : 4'd0;

    st_t                  st_r;
    logic [3:0]           cnt_r;
    logic [BANK_BITS-1:0] bank_r;
    logic [1:0]           cfg_r;
    logic                 rdy_r;
    logic                 ba_r;

    logic                 io_s;
    logic [2:0]           slot_s;
    logic                 slot_ok_s;
    logic                 mmu_s;
    logic                 rom_s;
    logic                 slow_s;
    logic                 dma_take_s;
    logic [BANK_BITS-1:0] bank_sel_s;
    logic                 unused_s;

    assign io_s       = (A[15:10] == IO_BASE);
    assign slot_s     = A[9:7];
    assign slot_ok_s  = ({1'b0, slot_s} < NSLOTS4);
    assign mmu_s      = io_s && (slot_s == 3'd7);
    assign rom_s      = A[15] && R_W && !io_s &&
                        ((!A[14] && cfg_r[0]) || (A[14] && cfg_r[1]));
    assign slow_s     = io_s && slot_ok_s && SLOW8[slot_s] && HAS_WAIT;
    assign dma_take_s = !_DMA && SYNC;
    assign bank_sel_s = (A[15:14] == 2'b01) ? bank_r : {BANK_BITS{1'b0}};
    assign unused_s   = ^{A[6:1], D};

    // Output decode: reset forces everything idle, DMA keeps only RAM selects and banking
    always_comb begin
        RDY    = rdy_r;
        BA     = ba_r;
        BANK   = {BANK_BITS{1'b0}};
        DOE    = 1'b0;
        DOUT   = 8'h00;
        _RAM0  = 1'b1;
        _RAM1  = 1'b1;
        _ROM   = 1'b1;
        _IO    = 1'b1;
        _CS_RD = {NSLOTS{1'b1}};
        _CS_WR = {NSLOTS{1'b1}};
        if (RESET) begin
            RDY = 1'b1;
            BA  = 1'b0;
        end else if (st_r == ST_DMA) begin
            _RAM0 = A[15];
            _RAM1 = !A[15];
            BANK  = bank_sel_s;
        end else begin
            _IO   = !io_s;
            _ROM  = !rom_s;
            _RAM0 = A[15];
            _RAM1 = !(A[15] && !io_s && !rom_s);
            BANK  = bank_sel_s;
            for (int s = 0; s < NSLOTS; s++) begin
                _CS_RD[s] = !(io_s && (slot_s == 3'(s)) && R_W);
                _CS_WR[s] = !(io_s && (slot_s == 3'(s)) && !R_W);
            end
            if (mmu_s && R_W) begin
                DOE  = 1'b1;
                DOUT = A[0] ? {6'b000000, cfg_r} : 8'(bank_r);
            end else begin
                DOE  = 1'b0;
                DOUT = 8'h00;
            end
            // the only RDY change not tied to a state edge: first cycle of a slow access
            if ((st_r == ST_RUN) && slow_s && !dma_take_s) begin
                RDY = 1'b0;
            end else begin
                RDY = rdy_r;
            end
        end
    end

    // MMU registers and the wait-state / DMA handoff FSM
    always_ff @(posedge PHI2) begin
        if (RESET) begin
            st_r   <= ST_RUN;
            cnt_r  <= 4'd0;
            bank_r <= {BANK_BITS{1'b0}};
            cfg_r  <= 2'b11;
            rdy_r  <= 1'b1;
            ba_r   <= 1'b0;
        end else begin
            if (((st_r == ST_RUN) || (st_r == ST_DONE)) && mmu_s && !R_W) begin
                if (A[0]) begin
                    cfg_r <= D[1:0];
                end else begin
                    bank_r <= D[BANK_BITS-1:0];
                end
            end
            case (st_r)
                ST_RUN: begin
                    if (dma_take_s) begin
                        st_r  <= ST_DMA;
                        rdy_r <= 1'b0;
                        ba_r  <= 1'b1;
                    end else if (slow_s) begin
                        cnt_r <= CNT_INIT;
                        if (ONE_WAIT) begin
                            st_r  <= ST_DONE;
                            rdy_r <= 1'b1;
                        end else begin
                            st_r  <= ST_STALL;
                            rdy_r <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (cnt_r == 4'd0) begin
                        st_r  <= ST_DONE;
                        rdy_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    st_r  <= ST_RUN;
                    rdy_r <= 1'b1;
                end
                ST_DMA: begin
                    if (_DMA) begin
                        st_r  <= ST_RUN;
                        rdy_r <= 1'b1;
                        ba_r  <= 1'b0;
                    end
                end
                default: begin
                    st_r  <= ST_RUN;
                    rdy_r <= 1'b1;
                    ba_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc256_mmu_gen.sv
// Bench for lc256_mmu_gen: vector table plus hand sequences fed through an expected-value queue;
// two extra instances with WAIT_CYC=1 and WAIT_CYC=0 cover the other wait-state lengths.
module tb_lc256_mmu_gen;

    typedef struct packed {
        logic       rdy;
        logic       ba;
        logic [1:0] bank;
        logic       ram0;
        logic       ram1;
        logic       rom;
        logic       io;
        logic [3:0] rd;
        logic [3:0] wr;
        logic       doe;
        logic [7:0] dout;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [15:0] a;
        logic       rw;
        logic       sync;
        logic       dman;
        logic [7:0] d;
        exp_t       exp;
    } vec_t;

    logic        phi2 = 1'b0;
    logic        reset_s = 1'b1;
    logic [15:0] a_s = 16'h0000;
    logic [15:0] a_alt_s = 16'h0000;
    logic        rw_s = 1'b1;
    logic        sync_s = 1'b0;
    logic        dman_s = 1'b1;
    logic [7:0]  d_s = 8'h00;

    logic [7:0]  dout;
    logic        doe, rdy, ba, ram0, ram1, rom, io;
    logic [1:0]  bank;
    logic [3:0]  cs_rd, cs_wr;

    logic [7:0]  x_dout [2];
    logic        x_doe [2], x_rdy [2], x_ba [2], x_ram0 [2], x_ram1 [2], x_rom [2], x_io [2];
    logic [1:0]  x_bank [2];
    logic [3:0]  x_rd [2], x_wr [2];

    exp_t  exp_q [$];
    string name_q [$];
    vec_t  vecs [$];
    int    errors = 0;
    int    checks = 0;
    logic  smp_w1, smp_w0;

    always #5 phi2 = ~phi2;

    lc256_mmu_gen dut (
        .PHI2(phi2), .RESET(reset_s), .A(a_s), .R_W(rw_s), .SYNC(sync_s), ._DMA(dman_s), .D(d_s),
        .DOUT(dout), .DOE(doe), .RDY(rdy), .BA(ba), .BANK(bank),
        ._RAM0(ram0), ._RAM1(ram1), ._ROM(rom), ._IO(io), ._CS_RD(cs_rd), ._CS_WR(cs_wr)
    );

    lc256_mmu_gen #(.WAIT_CYC(1)) dut_w1 (
        .PHI2(phi2), .RESET(reset_s), .A(a_alt_s), .R_W(rw_s), .SYNC(sync_s), ._DMA(dman_s), .D(d_s),
        .DOUT(x_dout[0]), .DOE(x_doe[0]), .RDY(x_rdy[0]), .BA(x_ba[0]), .BANK(x_bank[0]),
        ._RAM0(x_ram0[0]), ._RAM1(x_ram1[0]), ._ROM(x_rom[0]), ._IO(x_io[0]),
        ._CS_RD(x_rd[0]), ._CS_WR(x_wr[0])
    );

    lc256_mmu_gen #(.WAIT_CYC(0)) dut_w0 (
        .PHI2(phi2), .RESET(reset_s), .A(a_alt_s), .R_W(rw_s), .SYNC(sync_s), ._DMA(dman_s), .D(d_s),
        .DOUT(x_dout[1]), .DOE(x_doe[1]), .RDY(x_rdy[1]), .BA(x_ba[1]), .BANK(x_bank[1]),
        ._RAM0(x_ram0[1]), ._RAM1(x_ram1[1]), ._ROM(x_rom[1]), ._IO(x_io[1]),
        ._CS_RD(x_rd[1]), ._CS_WR(x_wr[1])
    );

    function automatic exp_t e(input logic r, input logic b, input logic [1:0] bk,
                               input logic r0, input logic r1, input logic rm, input logic i,
                               input logic [3:0] rd, input logic [3:0] wr,
                               input logic oe, input logic [7:0] dv);
        exp_t x;
        x.rdy = r;  x.ba = b;  x.bank = bk; x.ram0 = r0; x.ram1 = r1; x.rom = rm; x.io = i;
        x.rd = rd;  x.wr = wr; x.doe = oe;  x.dout = dv;
        return x;
    endfunction

    task automatic add(input string n, input logic rst, input logic [15:0] a, input logic rw,
                       input logic sy, input logic dm, input logic [7:0] d, input exp_t x);
        vec_t v;
        v.name = n; v.rst = rst; v.a = a; v.rw = rw; v.sync = sy; v.dman = dm; v.d = d; v.exp = x;
        vecs.push_back(v);
    endtask

    // drive one cycle, queue its expectation, compare mid-cycle, then advance past the edge
    task automatic apply(input vec_t v);
        exp_t  got, want, mask;
        string nm;
        reset_s = v.rst; a_s = v.a; rw_s = v.rw; sync_s = v.sync; dman_s = v.dman; d_s = v.d;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge phi2);
        got = {rdy, ba, bank, ram0, ram1, rom, io, cs_rd, cs_wr, doe, dout};
        smp_w1 = x_rdy[0];
        smp_w0 = x_rdy[1];
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            mask = '1;
            if (!want.doe) mask.dout = 8'h00;
            if ((got & mask) !== (want & mask)) begin
                errors++;
                $display("FAIL %s: got %b required %b", nm, got & mask, want & mask);
            end
        end
        @(posedge phi2);
        #1;
    endtask

    task automatic aux_check(input string n, input logic w1, input logic w0);
        checks++;
        if (smp_w1 !== w1) begin
            errors++;
            $display("FAIL %s_w1: RDY got %b required %b", n, smp_w1, w1);
        end
        checks++;
        if (smp_w0 !== w0) begin
            errors++;
            $display("FAIL %s_w0: RDY got %b required %b", n, smp_w0, w0);
        end
    endtask

    initial begin
        exp_t idle, ram_lo, slow2, mmu, dma_lo;
        vec_t v;
        idle   = e(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00);
        ram_lo = e(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00);
        slow2  = e(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 4'hF, 1'b0, 8'h00);
        mmu    = e(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 8'h00);
        dma_lo = e(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00);

        // decode table: reset, MMU regs, banking, ROM enables, fast slots
        add("reset",       1'b1, 16'hDF80, 1'b1, 1'b0, 1'b1, 8'h00, idle);
        add("rd_bank_rst", 1'b0, 16'hDF80, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h00));
        add("rd_cfg_rst",  1'b0, 16'hDF81, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h03));
        add("wr_bank",     1'b0, 16'hDF80, 1'b0, 1'b0, 1'b1, 8'h02, mmu);
        add("bank_win",    1'b0, 16'h4123, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,2,0,1,1,1,4'hF,4'hF,0,8'h00));
        add("roml_on",     1'b0, 16'h8123, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,0,1,4'hF,4'hF,0,8'h00));
        add("romh_on",     1'b0, 16'hE000, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,0,1,4'hF,4'hF,0,8'h00));
        add("wr_cfg0",     1'b0, 16'hDF81, 1'b0, 1'b0, 1'b1, 8'h00, mmu);
        add("romh_off",    1'b0, 16'hE000, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("roml_off",    1'b0, 16'h8123, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("rd_cfg0",     1'b0, 16'hDF81, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h00));
        add("rd_bank2",    1'b0, 16'hDF80, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h02));
        add("wr_cfg1",     1'b0, 16'hDF81, 1'b0, 1'b0, 1'b1, 8'h01, mmu);
        add("roml_only",   1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,0,1,4'hF,4'hF,0,8'h00));
        add("romh_only",   1'b0, 16'hC000, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("rom_write",   1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 8'h00, e(1,0,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("wr_cfg3",     1'b0, 16'hDF81, 1'b0, 1'b0, 1'b1, 8'h03, mmu);
        add("slot0_wr",    1'b0, 16'hDC00, 1'b0, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hE,0,8'h00));
        add("slot1_rd",    1'b0, 16'hDC80, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hD,4'hF,0,8'h00));
        add("slot3_wr",    1'b0, 16'hDD80, 1'b0, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'h7,0,8'h00));
        add("slot5_none",  1'b0, 16'hDE80, 1'b1, 1'b0, 1'b1, 8'h00, mmu);
        add("ram_lo",      1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, ram_lo);
        add("bank_top",    1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 8'h00, e(1,0,2,0,1,1,1,4'hF,4'hF,0,8'h00));
        add("dma_nosync1", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, ram_lo);
        add("dma_nosync2", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, ram_lo);

        @(posedge phi2);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();

        // slow slot 2 with WAIT_CYC=2: RDY 0,0,1 with the strobe held, then back to RUN
        add("slow_run",    1'b0, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, slow2);
        add("slow_stall",  1'b0, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, slow2);
        add("slow_done",   1'b0, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hB,4'hF,0,8'h00));
        add("slow_after",  1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, ram_lo);
        // DMA handoff; a register write while granted must be ignored
        add("dma_req",     1'b0, 16'hDC00, 1'b1, 1'b1, 1'b0, 8'h00, e(1,0,0,1,1,1,0,4'hE,4'hF,0,8'h00));
        add("dma_io",      1'b0, 16'hDC00, 1'b1, 1'b0, 1'b0, 8'h00, e(0,1,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("dma_bank",    1'b0, 16'h4123, 1'b1, 1'b0, 1'b0, 8'h00, e(0,1,2,0,1,1,1,4'hF,4'hF,0,8'h00));
        add("dma_wr_ign",  1'b0, 16'hDF80, 1'b0, 1'b0, 1'b0, 8'h01, e(0,1,0,1,0,1,1,4'hF,4'hF,0,8'h00));
        add("dma_release", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, dma_lo);
        add("dma_back",    1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, ram_lo);
        add("dma_bank_kept", 1'b0, 16'hDF80, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h02));
        // DMA request on a slow access wins, no stall
        add("coll_dma",    1'b0, 16'hDD00, 1'b1, 1'b1, 1'b0, 8'h00, e(1,0,0,1,1,1,0,4'hB,4'hF,0,8'h00));
        add("coll_dma2",   1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, dma_lo);
        add("coll_run",    1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, ram_lo);
        // DMA request during a stall waits for RUN and a fresh SYNC
        add("st_run",      1'b0, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, slow2);
        add("st_stall",    1'b0, 16'hDD00, 1'b1, 1'b1, 1'b0, 8'h00, slow2);
        add("st_done",     1'b0, 16'hDD00, 1'b1, 1'b1, 1'b0, 8'h00, e(1,0,0,1,1,1,0,4'hB,4'hF,0,8'h00));
        add("st_nosync",   1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, ram_lo);
        add("st_sync",     1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, ram_lo);
        add("st_dma",      1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, dma_lo);
        // reset while in DMA and while stalled
        add("rst_in_dma",  1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, idle);
        add("rst_reinit",  1'b0, 16'hDF80, 1'b1, 1'b0, 1'b1, 8'h00, e(1,0,0,1,1,1,0,4'hF,4'hF,1,8'h00));
        add("rst_st_run",  1'b0, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, slow2);
        add("rst_stall",   1'b1, 16'hDD00, 1'b1, 1'b0, 1'b1, 8'h00, idle);
        add("rst_after",   1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, ram_lo);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // WAIT_CYC=1 gives one low cycle, WAIT_CYC=0 none
        a_alt_s = 16'hDD00;
        v.name = "aux0"; v.rst = 1'b0; v.a = 16'h0000; v.rw = 1'b1; v.sync = 1'b0;
        v.dman = 1'b1; v.d = 8'h00; v.exp = ram_lo;
        apply(v);
        aux_check("aux_c0", 1'b0, 1'b1);
        v.name = "aux1";
        apply(v);
        aux_check("aux_c1", 1'b1, 1'b1);
        a_alt_s = 16'h0000;
        v.name = "aux2";
        apply(v);
        aux_check("aux_c2", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
